pc_redirect_unit: RTL

- Fetch-side PC sequencer and branch-redirect consumer for the 5-stage MIPS pipeline.
- Takes the D-stage comparator result and branch/jump decode, and computes the architectural next-fetch PC with one delay slot.
- Drives a single-outstanding instruction-memory request/ack handshake and presents fetched instructions to the F/D register.

---
 rtl/pc_redirect_unit.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pc_redirect_unit.sv
// -----------------------------------------------------------------------------
// pc_redirect_unit
//
// Fetch-side PC sequencer for a 5-stage MIPS pipeline with one branch delay
// slot. It issues one instruction-memory request at a time and holds the
// fetched word for the F/D register. It also evaluates the D-stage
// branch/jump decision and steers the fetch that follows the delay slot.
//
// Parameters:
//   RESET_PC     first fetch address after reset
//
// Ports:
//   clk, reset   rising-edge clock; asynchronous active-high reset
//   stall        hazard freeze of F/D (D does not accept while high)
//   br_valid     D holds a branch/jump (ignored while stall is high)
//   br_type      0 BEQ,1 BNE,2 BGTZ,3 BLEZ,4 BLTZ,5 BGEZ,6 J/JAL,7 JR/JALR
//   cmp_out      D-stage compare flag (eq / gtz / ltz depending on br_type)
//   pc_d         PC of the D-stage instruction
//   imm16        branch offset (words, sign-extended)
//   instr_index  J-format target field
//   rs_val       forwarded rs for JR/JALR
//   imem_req/imem_addr   registered fetch request, stable until imem_ack
//   imem_ack/imem_rdata  one-cycle data-valid pulse and instruction word
//   f_valid/instr_f/pc_f registered fetched instruction presented to D
//
// Optional feature (macro PC_ALIGN_CHECK_EN):
//   Adds output adel_f. A taken JR/JALR to a misaligned rs_val still
//   redirects, with target[1:0] forced to 0; adel_f is raised together with
//   f_valid of that redirected fetch and cleared when it is consumed.
// -----------------------------------------------------------------------------
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [2:0]  br_type,
  input  logic        cmp_out,
  input  logic [31:0] pc_d,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] rs_val,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        f_valid,
  output logic [31:0] instr_f,
  output logic [31:0] pc_f
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic        adel_f
`endif
);

  typedef enum logic {
    ST_ISSUE = 1'b0,  // request outstanding (or about to be issued)
    ST_HOLD  = 1'b1   // fetched word waiting for D to accept it
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        redir_pend_q, redir_pend_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic        f_valid_q, f_valid_d;
  logic [31:0] instr_f_q, instr_f_d;
  logic [31:0] pc_f_q, pc_f_d;

  // ---------------------------------------------------------------------------
  // Branch decision and target
  // ---------------------------------------------------------------------------
  logic        cond_true;
  logic [31:0] pc_d_plus4;
  logic [31:0] raw_target;
  logic [31:0] br_target;
  logic        br_fire;

  // NOTE: every variable assigned in an always_comb gets a value on every
  // path (defaults first or a full case with default) so no latch is inferred.
  always_comb begin
    pc_d_plus4 = pc_d + 32'd4;

    // Even conditional types take the flag as-is, odd ones take its inverse.
    case (br_type)
      3'd0, 3'd2, 3'd4: cond_true = cmp_out;
      3'd1, 3'd3, 3'd5: cond_true = !cmp_out;
      default:          cond_true = 1'b1;
    endcase

    case (br_type)
      3'd6:    raw_target = {pc_d_plus4[31:28], instr_index, 2'b00};
      3'd7:    raw_target = rs_val;
      default: raw_target = pc_d_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
    endcase
  end

  assign br_fire = br_valid && !stall && cond_true;

`ifdef PC_ALIGN_CHECK_EN
  logic jr_misaligned;
  logic fetch_adel_q, fetch_adel_d;  // flag travelling with the next request
  logic redir_adel_q, redir_adel_d;  // flag travelling with redir_pc_q
  logic adel_f_q, adel_f_d;

  assign jr_misaligned = (br_type == 3'd7) && (rs_val[1:0] != 2'b00);
  assign br_target     = jr_misaligned ? {raw_target[31:2], 2'b00} : raw_target;
`else
  assign br_target = raw_target;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    redir_pend_d = redir_pend_q;
    redir_pc_d   = redir_pc_q;
    imem_req_d   = imem_req_q;
    imem_addr_d  = imem_addr_q;
    f_valid_d    = f_valid_q;
    instr_f_d    = instr_f_q;
    pc_f_d       = pc_f_q;
`ifdef PC_ALIGN_CHECK_EN
    fetch_adel_d = fetch_adel_q;
    redir_adel_d = redir_adel_q;
    adel_f_d     = adel_f_q;
`endif

    case (state_q)
      ST_ISSUE: begin
        // The delay slot is still in flight, so a taken event only arms the
        // redirect; the outstanding request is left untouched.
        if (br_fire) begin
          redir_pend_d = 1'b1;
          redir_pc_d   = br_target;
`ifdef PC_ALIGN_CHECK_EN
          redir_adel_d = jr_misaligned;
`endif
        end
        // An ack only counts once the request is actually on the bus; right
        // after reset the request register is still low for one cycle.
        if (imem_req_q && imem_ack) begin
          instr_f_d  = imem_rdata;
          pc_f_d     = fetch_pc_q;
          f_valid_d  = 1'b1;
          imem_req_d = 1'b0;
          state_d    = ST_HOLD;
`ifdef PC_ALIGN_CHECK_EN
          adel_f_d   = fetch_adel_q;
`endif
        end else begin
          imem_req_d  = 1'b1;
          imem_addr_d = fetch_pc_q;
        end
      end

      ST_HOLD: begin
        // imem_ack is ignored here: no request is outstanding.
        if (!stall) begin
          // A taken event in the consume cycle is for the instruction being
          // consumed (the delay slot), so it steers this very next fetch.
          if (br_fire) begin
            fetch_pc_d = br_target;
          end else if (redir_pend_q) begin
            fetch_pc_d = redir_pc_q;
          end else begin
            fetch_pc_d = pc_f_q + 32'd4;
          end
`ifdef PC_ALIGN_CHECK_EN
          if (br_fire) begin
            fetch_adel_d = jr_misaligned;
          end else if (redir_pend_q) begin
            fetch_adel_d = redir_adel_q;
          end else begin
            fetch_adel_d = 1'b0;
          end
          redir_adel_d = 1'b0;
          adel_f_d     = 1'b0;
`endif
          redir_pend_d = 1'b0;
          f_valid_d    = 1'b0;
          // Request goes out straight away to sustain one fetch per 2 cycles.
          imem_req_d   = 1'b1;
          imem_addr_d  = fetch_pc_d;
          state_d      = ST_ISSUE;
        end
      end

      default: state_d = ST_ISSUE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_ISSUE;
      fetch_pc_q   <= RESET_PC;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= 32'h0;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= 32'h0;
      f_valid_q    <= 1'b0;
      instr_f_q    <= 32'h0;
      pc_f_q       <= 32'h0;
`ifdef PC_ALIGN_CHECK_EN
      fetch_adel_q <= 1'b0;
      redir_adel_q <= 1'b0;
      adel_f_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
      f_valid_q    <= f_valid_d;
      instr_f_q    <= instr_f_d;
      pc_f_q       <= pc_f_d;
`ifdef PC_ALIGN_CHECK_EN
      fetch_adel_q <= fetch_adel_d;
      redir_adel_q <= redir_adel_d;
      adel_f_q     <= adel_f_d;
`endif
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign f_valid   = f_valid_q;
  assign instr_f   = instr_f_q;
  assign pc_f      = pc_f_q;
`ifdef PC_ALIGN_CHECK_EN
  assign adel_f    = adel_f_q;
`endif

endmodule
